esfa_run_sequencer: RTL and testbench

Hardware initiator for the ESFATop run handshake. It drives `doRun`, tracks `isRunning`/`wasSuccessful`, and executes a programmed batch of back-to-back runs. For each run it counts pass, fail and timeout outcomes and measures run latency in clock cycles. It sits beside ESFATop on the FPGA, so benchmarks run without a simulation bench, and its counters are read out after `done`.

---
 rtl/esfa_bench_pkg.sv | 47 ++++
 rtl/esfa_sat_counter.sv | 49 ++++
 rtl/esfa_run_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_esfa_run_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esfa_bench_pkg.sv
// ---------------------------------------------------------------------------
// esfa_bench_pkg
// Shared definitions for the ESFATop run sequencer:
//   - state_e      : sequencer FSM state encoding
//   - DEF_*        : default batch size, widths and timeouts
//   - sat_inc()    : saturating increment for counters of any width <= 64
// No ports (package).
// ---------------------------------------------------------------------------
package esfa_bench_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RUNNING  = 3'd3,
        ST_RECORD   = 3'd4,
        ST_TIMEOUT  = 3'd5,
        ST_GAP      = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

    localparam int unsigned DEF_NUM_RUNS    = 32'd16;
    localparam int unsigned DEF_CNT_W       = 32'd16;
    localparam int unsigned DEF_CYC_W       = 32'd32;
    localparam int unsigned DEF_ACK_TIMEOUT = 32'd64;
    localparam int unsigned DEF_RUN_TIMEOUT = 32'd50000;
    localparam int unsigned DEF_GAP_CYCLES  = 32'd4;

    // Widest counter the helper below can serve.
    localparam int unsigned SAT_MAX_W = 32'd64;

    // Increment v, holding at the all-ones value of a w-bit counter.
    // Callers zero-extend into SAT_MAX_W bits and truncate the result back.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] v,
        input int unsigned          w
    );
        logic [SAT_MAX_W-1:0] lim;
        lim = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
        if (v >= lim) begin
            sat_inc = lim;
        end else begin
            sat_inc = v + 64'd1;
        end
    endfunction

endpackage

// File: rtl/esfa_sat_counter.sv
// ---------------------------------------------------------------------------
// esfa_sat_counter
// Saturating up-counter with a synchronous clear (load-zero) input.
// Ports:
//   clk   in  1 : clock
//   reset in  1 : synchronous active-high reset (q -> 0)
//   clr   in  1 : load zero on the next edge (wins over inc)
//   inc   in  1 : increment on the next edge, holding at all-ones
//   q     out W : registered count
// ---------------------------------------------------------------------------
module esfa_sat_counter
    import esfa_bench_pkg::*;
#(
    parameter int unsigned W = 32'd16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = W'(sat_inc(SAT_MAX_W'(q_q), W));
        end else begin
            q_d = q_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/esfa_run_sequencer.sv
// ---------------------------------------------------------------------------
// esfa_run_sequencer
// Hardware initiator for the ESFATop doRun/isRunning/wasSuccessful handshake.
// Executes NUM_RUNS back-to-back runs per batch, counting pass / fail /
// timeout outcomes and measuring per-run latency in clock cycles.
//
// Build option: define ESFA_RUN_STATS_EN to build the max_cycles and
// total_cycles statistics; otherwise both ports are tied to zero.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle pulse, accepted only in IDLE or DONE
//   doRun               : registered run request to ESFATop
//   isRunning           : ESFATop busy flag
//   wasSuccessful       : ESFATop result, sampled after isRunning falls
//   busy / done         : batch in progress / batch finished (level)
//   pass_count, fail_count, timeout_count : saturating outcome counters
//   last_cycles         : latency of the latest run (all-ones on timeout)
//   max_cycles, total_cycles : optional latency statistics
// ---------------------------------------------------------------------------
module esfa_run_sequencer
    import esfa_bench_pkg::*;
#(
    parameter int unsigned NUM_RUNS    = DEF_NUM_RUNS,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned CYC_W       = DEF_CYC_W,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned RUN_TIMEOUT = DEF_RUN_TIMEOUT,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             doRun,
    input  logic             isRunning,
    input  logic             wasSuccessful,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CYC_W-1:0] last_cycles,
    output logic [CYC_W-1:0] max_cycles,
    output logic [CYC_W-1:0] total_cycles
);

    // The state timer must reach the largest of the three per-state limits.
    localparam int unsigned TMR_AR  = (ACK_TIMEOUT > RUN_TIMEOUT) ? ACK_TIMEOUT : RUN_TIMEOUT;
    localparam int unsigned TMR_MAX = (TMR_AR > GAP_CYCLES) ? TMR_AR : GAP_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 32'd1);
    localparam int unsigned IDX_W   = (NUM_RUNS > 32'd1) ? $clog2(NUM_RUNS) : 32'd1;

    localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 32'd1);
    localparam logic [TMR_W-1:0] RUN_LAST = TMR_W'(RUN_TIMEOUT - 32'd1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 32'd1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RUNS - 32'd1);

    state_e             state_q;
    state_e             state_d;

    logic               do_run_q;
    logic               do_run_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;
    logic [IDX_W-1:0]   run_idx_q;
    logic [IDX_W-1:0]   run_idx_d;
    logic [CYC_W-1:0]   last_q;
    logic [CYC_W-1:0]   last_d;

    logic               start_acc;
    logic               pass_inc;
    logic               fail_inc;
    logic               to_inc;
    logic               lat_clr;
    logic               lat_inc;
    logic               tmr_clr;
    logic [TMR_W-1:0]   tmr_val;
    logic [CYC_W-1:0]   lat_val;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A falling isRunning is checked before the run
    // timer so that a drop on the expiry cycle counts as a completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ARM;
                else       state_d = ST_IDLE;
            end
            ST_ARM: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (isRunning)                state_d = ST_RUNNING;
                else if (tmr_val == ACK_LAST) state_d = ST_TIMEOUT;
                else                          state_d = ST_WAIT_ACK;
            end
            ST_RUNNING: begin
                if (!isRunning)               state_d = ST_RECORD;
                else if (tmr_val == RUN_LAST) state_d = ST_TIMEOUT;
                else                          state_d = ST_RUNNING;
            end
            ST_RECORD: begin
                state_d = ST_GAP;
            end
            ST_TIMEOUT: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tmr_val == GAP_LAST) begin
                    if (run_idx_q == IDX_LAST) state_d = ST_DONE;
                    else                       state_d = ST_ARM;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_ARM;
                else       state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath control derived from the current/next state.
    always_comb begin
        start_acc = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
        // doRun is requested from ARM through the run; the register makes it
        // visible one cycle later and drops it on the edge out of RECORD/TIMEOUT.
        do_run_d  = (state_q == ST_ARM) || (state_q == ST_WAIT_ACK) ||
                    (state_q == ST_RUNNING);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);

        pass_inc  = (state_q == ST_RECORD) && wasSuccessful;
        fail_inc  = (state_q == ST_RECORD) && !wasSuccessful;
        to_inc    = (state_q == ST_TIMEOUT);

        // Latency is zero in ARM and counts every cycle up to, but not
        // including, the RUNNING cycle that sees isRunning low.
        lat_clr   = (state_d == ST_ARM);
        lat_inc   = (state_q == ST_ARM) || (state_q == ST_WAIT_ACK) ||
                    ((state_q == ST_RUNNING) && isRunning);

        // The state timer restarts at 0 on every state change.
        tmr_clr   = (state_d != state_q);

        if (start_acc) begin
            run_idx_d = '0;
        end else if ((state_q == ST_GAP) && (state_d == ST_ARM)) begin
            run_idx_d = run_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            run_idx_d = run_idx_q;
        end

        if (start_acc) begin
            last_d = '0;
        end else if (state_q == ST_RECORD) begin
            last_d = lat_val;
        end else if (state_q == ST_TIMEOUT) begin
            last_d = '1;
        end else begin
            last_d = last_q;
        end
    end

    // Registered outputs and batch bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            do_run_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            run_idx_q <= '0;
            last_q    <= '0;
        end else begin
            do_run_q  <= do_run_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            run_idx_q <= run_idx_d;
            last_q    <= last_d;
        end
    end

    assign doRun       = do_run_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign last_cycles = last_q;

    esfa_sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc),
        .inc   (pass_inc),
        .q     (pass_count)
    );

    esfa_sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc),
        .inc   (fail_inc),
        .q     (fail_count)
    );

    esfa_sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc),
        .inc   (to_inc),
        .q     (timeout_count)
    );

    esfa_sat_counter #(.W(CYC_W)) u_lat_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (lat_clr),
        .inc   (lat_inc),
        .q     (lat_val)
    );

    esfa_sat_counter #(.W(TMR_W)) u_state_tmr (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .inc   (1'b1),
        .q     (tmr_val)
    );

`ifdef ESFA_RUN_STATS_EN
    logic [CYC_W-1:0] max_q;
    logic [CYC_W-1:0] max_d;
    logic [CYC_W-1:0] total_q;
    logic [CYC_W-1:0] total_d;
    logic [CYC_W:0]   sum_s;

    // Statistics update: only completed (non-timeout) runs contribute.
    always_comb begin
        sum_s = {1'b0, total_q} + {1'b0, lat_val};
        if (start_acc) begin
            max_d   = '0;
            total_d = '0;
        end else if (state_q == ST_RECORD) begin
            max_d   = (lat_val > max_q) ? lat_val : max_q;
            total_d = sum_s[CYC_W] ? {CYC_W{1'b1}} : sum_s[CYC_W-1:0];
        end else begin
            max_d   = max_q;
            total_d = total_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_q   <= '0;
            total_q <= '0;
        end else begin
            max_q   <= max_d;
            total_q <= total_d;
        end
    end

    assign max_cycles   = max_q;
    assign total_cycles = total_q;
`else
    assign max_cycles   = '0;
    assign total_cycles = '0;
`endif

endmodule

// File: tb/tb_esfa_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_esfa_run_sequencer
// Two sequencer instances share one clock and reset:
//   inst 0 : NUM_RUNS=4, CNT_W=16, ACK_TIMEOUT=8
//   inst 1 : NUM_RUNS=6, CNT_W=2 (saturation)
// A negedge responder plays ESFATop for each instance: isRunning rises
// dly cycles after doRun is first seen and stays high for hold cycles,
// which gives a run latency of dly + hold + 1.
// ---------------------------------------------------------------------------
module tb_esfa_run_sequencer;

    localparam int GAP    = 4;
    localparam int A_RUNS = 4;
    localparam int B_RUNS = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_s [0:1];
    logic isrun_s [0:1] = '{1'b0, 1'b0};
    logic succ_s  [0:1] = '{1'b0, 1'b0};

    logic        dorun_a, busy_a, done_a;
    logic [15:0] pass_a, fail_a, to_a;
    logic [31:0] last_a, max_a, total_a;
    logic        dorun_b, busy_b, done_b;
    logic [1:0]  pass_b, fail_b, to_b;
    logic [31:0] last_b, max_b, total_b;

    esfa_run_sequencer #(.NUM_RUNS(A_RUNS), .ACK_TIMEOUT(8), .GAP_CYCLES(GAP)) u_a (
        .clk(clk), .reset(reset), .start(start_s[0]), .doRun(dorun_a),
        .isRunning(isrun_s[0]), .wasSuccessful(succ_s[0]), .busy(busy_a), .done(done_a),
        .pass_count(pass_a), .fail_count(fail_a), .timeout_count(to_a),
        .last_cycles(last_a), .max_cycles(max_a), .total_cycles(total_a)
    );

    esfa_run_sequencer #(.NUM_RUNS(B_RUNS), .CNT_W(2), .GAP_CYCLES(GAP)) u_b (
        .clk(clk), .reset(reset), .start(start_s[1]), .doRun(dorun_b),
        .isRunning(isrun_s[1]), .wasSuccessful(succ_s[1]), .busy(busy_b), .done(done_b),
        .pass_count(pass_b), .fail_count(fail_b), .timeout_count(to_b),
        .last_cycles(last_b), .max_cycles(max_b), .total_cycles(total_b)
    );

    // Uniform per-instance views.
    logic        dorun_w [0:1];
    logic        busy_w  [0:1];
    logic        done_w  [0:1];
    logic [31:0] pass_w  [0:1];
    logic [31:0] fail_w  [0:1];
    logic [31:0] to_w    [0:1];
    logic [31:0] last_w  [0:1];
    logic [31:0] max_w   [0:1];
    logic [31:0] total_w [0:1];
    assign dorun_w[0] = dorun_a;          assign dorun_w[1] = dorun_b;
    assign busy_w[0]  = busy_a;           assign busy_w[1]  = busy_b;
    assign done_w[0]  = done_a;           assign done_w[1]  = done_b;
    assign pass_w[0]  = {16'd0, pass_a};  assign pass_w[1]  = {30'd0, pass_b};
    assign fail_w[0]  = {16'd0, fail_a};  assign fail_w[1]  = {30'd0, fail_b};
    assign to_w[0]    = {16'd0, to_a};    assign to_w[1]    = {30'd0, to_b};
    assign last_w[0]  = last_a;           assign last_w[1]  = last_b;
    assign max_w[0]   = max_a;            assign max_w[1]   = max_b;
    assign total_w[0] = total_a;          assign total_w[1] = total_b;

    typedef struct {
        int          inst;
        int          dly;
        logic [63:0] holds;      // hold for run r in holds[r*8 +: 8]
        int          alt;        // 1: wasSuccessful alternates 1,0,1,...
        int          never_ack;  // 1: isRunning never rises
        int          check_gap;
        int          poke_start; // 1: pulse start again mid-batch
        logic [31:0] exp_pass;
        logic [31:0] exp_fail;
        logic [31:0] exp_to;
        logic [31:0] exp_last;
        logic [31:0] exp_max;
        logic [31:0] exp_total;
    } vec_t;

    vec_t vecs [0:4];
    vec_t exp_q [$];

    // Responder configuration (written by the stimulus only).
    int          cfg_dly   [0:1];
    logic [63:0] cfg_holds [0:1];
    int          cfg_alt   [0:1];
    int          cfg_never [0:1];

    // Responder / monitor state (written by the responder only).
    int rk          [0:1] = '{-1, -1};
    int cur_hold    [0:1] = '{0, 0};
    int batch_idx   [0:1] = '{0, 0};
    int total_rises [0:1] = '{0, 0};
    int overlap  = 0;
    int low_len  = 0;
    int gap_armed = 0;
    int gap_min  = 999;
    int gap_max  = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ESFATop model plus doRun gap and busy/done monitors.
    always @(negedge clk) begin
        int r;
        for (int i = 0; i < 2; i++) begin
            if (busy_w[i] && done_w[i]) overlap++;
            if (!busy_w[i]) batch_idx[i] = 0;
            if (!dorun_w[i]) begin
                rk[i]      = -1;
                isrun_s[i] = 1'b0;
            end else begin
                if (rk[i] < 0) begin
                    rk[i]       = 0;
                    r           = batch_idx[i] & 7;
                    cur_hold[i] = int'(cfg_holds[i][r*8 +: 8]);
                    succ_s[i]   = (cfg_alt[i] != 0) ? (r % 2 == 0) : 1'b1;
                    batch_idx[i]++;
                    total_rises[i]++;
                end else begin
                    rk[i]++;
                end
                isrun_s[i] = (cfg_never[i] == 0) && (rk[i] >= cfg_dly[i]) &&
                             (rk[i] < cfg_dly[i] + cur_hold[i]);
            end
        end
        if (!busy_w[0]) gap_armed = 0;
        if (!dorun_w[0]) begin
            low_len++;
        end else begin
            if (low_len > 0) begin
                if (gap_armed != 0) begin
                    if (low_len < gap_min) gap_min = low_len;
                    if (low_len > gap_max) gap_max = low_len;
                end else begin
                    gap_min = 999;
                    gap_max = 0;
                end
                gap_armed = 1;
            end
            low_len = 0;
        end
    end

    task automatic apply_cfg(input vec_t v);
        cfg_dly[v.inst]   = v.dly;
        cfg_holds[v.inst] = v.holds;
        cfg_alt[v.inst]   = v.alt;
        cfg_never[v.inst] = v.never_ack;
    endtask

    task automatic run_batch(input int vi);
        vec_t v;
        vec_t e;
        int   i;
        int   n;
        int   base;
        int   runs;
        v    = vecs[vi];
        i    = v.inst;
        runs = (i == 0) ? A_RUNS : B_RUNS;
        apply_cfg(v);
        base = total_rises[i];
        @(negedge clk);
        start_s[i] = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start_s[i] = 1'b0;
        // ARM cycle: busy already up, doRun not yet registered.
        chk($sformatf("v%0d_busy_arm", vi), {31'd0, busy_w[i]}, 32'd1);
        chk($sformatf("v%0d_done_arm", vi), {31'd0, done_w[i]}, 32'd0);
        chk($sformatf("v%0d_dorun_arm", vi), {31'd0, dorun_w[i]}, 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_dorun_2edges", vi), {31'd0, dorun_w[i]}, 32'd1);
        if (v.poke_start != 0) begin
            repeat (8) @(negedge clk);
            start_s[i] = 1'b1;
            @(negedge clk);
            start_s[i] = 1'b0;
        end
        n = 0;
        while (!done_w[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        chk($sformatf("v%0d_done", vi), {31'd0, done_w[i]}, 32'd1);
        chk($sformatf("v%0d_busy_end", vi), {31'd0, busy_w[i]}, 32'd0);
        chk($sformatf("v%0d_pass", vi), pass_w[i], e.exp_pass);
        chk($sformatf("v%0d_fail", vi), fail_w[i], e.exp_fail);
        chk($sformatf("v%0d_timeout", vi), to_w[i], e.exp_to);
        chk($sformatf("v%0d_last", vi), last_w[i], e.exp_last);
        chk($sformatf("v%0d_runs", vi), 32'(total_rises[i] - base), 32'(runs));
`ifdef ESFA_RUN_STATS_EN
        chk($sformatf("v%0d_max", vi), max_w[i], e.exp_max);
        chk($sformatf("v%0d_total", vi), total_w[i], e.exp_total);
`else
        chk($sformatf("v%0d_max", vi), max_w[i], 32'd0);
        chk($sformatf("v%0d_total", vi), total_w[i], 32'd0);
`endif
        if (e.check_gap != 0) begin
            // doRun is low for the GAP cycles plus the ARM cycle before it re-registers.
            chk($sformatf("v%0d_gap_min", vi), 32'(gap_min), 32'(GAP + 1));
            chk($sformatf("v%0d_gap_max", vi), 32'(gap_max), 32'(GAP + 1));
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{inst:0, dly:3, holds:{8{8'd10}}, alt:0, never_ack:0, check_gap:0, poke_start:0,
                    exp_pass:32'd4, exp_fail:32'd0, exp_to:32'd0, exp_last:32'd14,
                    exp_max:32'd14, exp_total:32'd56};
        vecs[1] = '{inst:1, dly:3, holds:{8{8'd10}}, alt:1, never_ack:0, check_gap:0, poke_start:0,
                    exp_pass:32'd3, exp_fail:32'd3, exp_to:32'd0, exp_last:32'd14,
                    exp_max:32'd14, exp_total:32'd84};
        vecs[2] = '{inst:0, dly:3, holds:{8{8'd10}}, alt:0, never_ack:1, check_gap:1, poke_start:0,
                    exp_pass:32'd0, exp_fail:32'd0, exp_to:32'd4, exp_last:32'hFFFF_FFFF,
                    exp_max:32'd0, exp_total:32'd0};
        // Minimum latency 2; six passes saturate the 2-bit counter at 3.
        vecs[3] = '{inst:1, dly:0, holds:{8{8'd1}}, alt:0, never_ack:0, check_gap:0, poke_start:1,
                    exp_pass:32'd3, exp_fail:32'd0, exp_to:32'd0, exp_last:32'd2,
                    exp_max:32'd2, exp_total:32'd12};
        // Latencies 10, 20, 15, 12.
        vecs[4] = '{inst:0, dly:3, holds:64'h0000_0000_080B_1006, alt:0, never_ack:0, check_gap:0,
                    poke_start:0, exp_pass:32'd4, exp_fail:32'd0, exp_to:32'd0, exp_last:32'd12,
                    exp_max:32'd20, exp_total:32'd57};
        for (int i = 0; i < 2; i++) begin
            start_s[i]   = 1'b0;
            cfg_dly[i]   = 3;
            cfg_holds[i] = {8{8'd10}};
            cfg_alt[i]   = 0;
            cfg_never[i] = 0;
        end

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dorun", {31'd0, dorun_a}, 32'd0);
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("rst_done",  {31'd0, done_a}, 32'd0);
        chk("rst_pass",  pass_w[0], 32'd0);
        chk("rst_fail",  fail_w[0], 32'd0);
        chk("rst_to",    to_w[0], 32'd0);
        chk("rst_last",  last_w[0], 32'd0);
        chk("rst_max",   max_w[0], 32'd0);
        chk("rst_total", total_w[0], 32'd0);

        for (int k = 0; k < 5; k++) run_batch(k);

        // Reset pulsed while run 2 of a batch is in RUNNING.
        apply_cfg(vecs[0]);
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        n = 0;
        while (!(batch_idx[0] == 2 && isrun_s[0]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("mid_reach_run2", {31'd0, isrun_s[0]}, 32'd1);
        chk("mid_pass_before", pass_w[0], 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_dorun", {31'd0, dorun_a}, 32'd0);
        chk("mid_busy",  {31'd0, busy_a}, 32'd0);
        chk("mid_done",  {31'd0, done_a}, 32'd0);
        chk("mid_pass",  pass_w[0], 32'd0);
        chk("mid_fail",  fail_w[0], 32'd0);
        chk("mid_to",    to_w[0], 32'd0);
        chk("mid_last",  last_w[0], 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_idle_dorun", {31'd0, dorun_a}, 32'd0);
        chk("mid_idle_pass",  pass_w[0], 32'd0);
        run_batch(0);

        chk("busy_done_excl", 32'(overlap), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
